// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter.
// Serialises one command byte onto the open-drain PS2_CLK/PS2_DAT pair using
// the host request-to-send sequence, then checks the device ACK bit. The lines
// are only ever pulled low; the enclosing level owns the actual tristates.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 6000,    // clock held low for request (120 us)
   parameter int unsigned START_TIMEOUT  = 750000,  // release -> first device falling edge (15 ms)
   parameter int unsigned BIT_TIMEOUT    = 100000   // between device falling edges (2 ms)
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic [7:0] send_data,
   input  logic       send_valid,
   output logic       tx_busy,
   output logic       send_done,
   output logic       send_error,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_pull,
   output logic       ps2_dat_pull
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_WAIT_FIRST,
      S_SHIFT,
      S_ACK,
      S_RELEASE,
      S_ERR
   } state_t;

   // dat_pull goes active one cycle before the clock is released, so the start
   // bit is already on the line when the device sees the clock rise.
   localparam logic [19:0] INH_DAT  = 20'(INHIBIT_CYCLES - 2);
   localparam logic [19:0] INH_LAST = 20'(INHIBIT_CYCLES - 1);
   localparam logic [19:0] START_T  = 20'(START_TIMEOUT);
   localparam logic [19:0] BIT_T    = 20'(BIT_TIMEOUT);

   state_t      state_q,     state_d;
   logic [19:0] cnt_q,       cnt_d;
   logic [3:0]  bitcnt_q,    bitcnt_d;
   logic [9:0]  shift_q,     shift_d;
   logic        busy_q,      busy_d;
   logic        done_q,      done_d;
   logic        err_q,       err_d;
   logic        clk_pull_q,  clk_pull_d;
   logic        dat_pull_q,  dat_pull_d;
   logic        clk_meta_q,  clk_meta_d;
   logic        clk_sync_q,  clk_sync_d;
   logic        clk_prev_q,  clk_prev_d;
   logic        dat_meta_q,  dat_meta_d;
   logic        dat_sync_q,  dat_sync_d;
   logic        fe;

   // Two-flop synchroniser per pin plus one history flop on the clock.
   always_comb begin
      clk_meta_d = ps2_clk_in;
      clk_sync_d = clk_meta_q;
      clk_prev_d = clk_sync_q;
      dat_meta_d = ps2_dat_in;
      dat_sync_d = dat_meta_q;
   end

   assign fe = clk_prev_q & ~clk_sync_q;

   // Next-state, datapath and output logic for the request/shift/ACK sequence.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path can leave
      // one unassigned and infer a latch.
      state_d    = state_q;
      cnt_d      = cnt_q + 20'd1;
      bitcnt_d   = bitcnt_q;
      shift_d    = shift_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      clk_pull_d = clk_pull_q;
      dat_pull_d = dat_pull_q;

      case (state_q)
         S_IDLE: begin
            // busy_q is still high in the done/error pulse cycle, so a request
            // arriving in that cycle is ignored.
            busy_d = 1'b0;
            cnt_d  = '0;
            if (send_valid && !busy_q) begin
               shift_d    = {1'b1, ~^send_data, send_data};
               bitcnt_d   = '0;
               busy_d     = 1'b1;
               clk_pull_d = 1'b1;
               dat_pull_d = 1'b0;
               state_d    = S_INHIBIT;
            end
         end

         S_INHIBIT: begin
            if (cnt_q >= INH_LAST) begin
               clk_pull_d = 1'b0;
               cnt_d      = '0;
               state_d    = S_WAIT_FIRST;
            end else if (cnt_q >= INH_DAT) begin
               dat_pull_d = 1'b1;
            end
         end

         S_WAIT_FIRST: begin
            if (fe) begin
               dat_pull_d = ~shift_q[0];
               shift_d    = {1'b1, shift_q[9:1]};
               bitcnt_d   = 4'd1;
               cnt_d      = '0;
               state_d    = S_SHIFT;
            end else if (cnt_q >= START_T) begin
               state_d = S_ERR;
            end
         end

         S_SHIFT: begin
            if (fe) begin
               dat_pull_d = ~shift_q[0];
               shift_d    = {1'b1, shift_q[9:1]};
               bitcnt_d   = bitcnt_q + 4'd1;
               cnt_d      = '0;
               if (bitcnt_q == 4'd9) begin
                  // This edge presents the stop bit: the line is released.
                  dat_pull_d = 1'b0;
                  state_d    = S_ACK;
               end
            end else if (cnt_q >= BIT_T) begin
               state_d = S_ERR;
            end
         end

         S_ACK: begin
            if (fe) begin
               bitcnt_d = 4'd11;
               cnt_d    = '0;
               state_d  = dat_sync_q ? S_ERR : S_RELEASE;
            end else if (cnt_q >= BIT_T) begin
               state_d = S_ERR;
            end
         end

         S_RELEASE: begin
            if (clk_sync_q && dat_sync_q) begin
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = S_IDLE;
            end else if (cnt_q >= BIT_T) begin
               state_d = S_ERR;
            end
         end

         S_ERR: begin
            clk_pull_d = 1'b0;
            dat_pull_d = 1'b0;
            err_d      = 1'b1;
            cnt_d      = '0;
            state_d    = S_IDLE;
         end

         default: begin
            clk_pull_d = 1'b0;
            dat_pull_d = 1'b0;
            cnt_d      = '0;
            state_d    = S_IDLE;
         end
      endcase
   end

   // State register with synchronous reset; reset releases both lines at once.
   always_ff @(posedge CLOCK_50) begin
      // NOTE: state uses non-blocking assignments so every flop samples the
      // values from before the edge, independent of statement order.
      if (!resetn) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bitcnt_q   <= '0;
         shift_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         clk_pull_q <= 1'b0;
         dat_pull_q <= 1'b0;
         // NOTE: the synchroniser resets to the idle (high) line level so
         // leaving reset can never fabricate a falling edge.
         clk_meta_q <= 1'b1;
         clk_sync_q <= 1'b1;
         clk_prev_q <= 1'b1;
         dat_meta_q <= 1'b1;
         dat_sync_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bitcnt_q   <= bitcnt_d;
         shift_q    <= shift_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         clk_pull_q <= clk_pull_d;
         dat_pull_q <= dat_pull_d;
         clk_meta_q <= clk_meta_d;
         clk_sync_q <= clk_sync_d;
         clk_prev_q <= clk_prev_d;
         dat_meta_q <= dat_meta_d;
         dat_sync_q <= dat_sync_d;
      end
   end

   assign tx_busy      = busy_q;
   assign send_done    = done_q;
   assign send_error   = err_q;
   assign ps2_clk_pull = clk_pull_q;
   assign ps2_dat_pull = dat_pull_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a behavioural keyboard
// that clocks the frame, captures the line bits and answers ACK or NACK.
module tb_ps2_host_tx;

   localparam int INH   = 6000;
   localparam int START = 1000;
   localparam int BITT  = 500;
   localparam int HALF  = 40;   // device clock half period in CLOCK_50 cycles

   logic       CLOCK_50 = 1'b0;
   logic       resetn = 1'b0;
   logic [7:0] send_data = 8'h00;
   logic       send_valid = 1'b0;
   logic       tx_busy, send_done, send_error;
   logic       ps2_clk_in, ps2_dat_in, ps2_clk_pull, ps2_dat_pull;
   logic       dev_clk = 1'b1;
   logic       dev_dat = 1'b1;

   int vectors = 0;
   int miscompares = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int clk_run = 0;
   int last_clk_run = 0;

   // Open-drain wired-AND of host pulls and device releases.
   assign ps2_clk_in = dev_clk & ~ps2_clk_pull;
   assign ps2_dat_in = dev_dat & ~ps2_dat_pull;

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .START_TIMEOUT (START),
      .BIT_TIMEOUT   (BITT)
   ) dut (
      .CLOCK_50    (CLOCK_50),
      .resetn      (resetn),
      .send_data   (send_data),
      .send_valid  (send_valid),
      .tx_busy     (tx_busy),
      .send_done   (send_done),
      .send_error  (send_error),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_dat_in  (ps2_dat_in),
      .ps2_clk_pull(ps2_clk_pull),
      .ps2_dat_pull(ps2_dat_pull)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   // Pulse counters and length of the most recent clk_pull high run.
   always @(negedge CLOCK_50) begin
      if (send_done)  done_cnt = done_cnt + 1;
      if (send_error) err_cnt  = err_cnt + 1;
      if (ps2_clk_pull) clk_run = clk_run + 1;
      else if (clk_run != 0) begin
         last_clk_run = clk_run;
         clk_run = 0;
      end
   end

   task automatic start_send(input logic [7:0] b);
      send_data  = b;
      send_valid = 1'b1;
      @(negedge CLOCK_50);
      send_valid = 1'b0;
   endtask

   task automatic wait_request(output logic seen);
      int n = 0;
      seen = 1'b0;
      while (!(ps2_clk_pull == 1'b0 && ps2_dat_pull == 1'b1) && n < 20000) begin
         @(negedge CLOCK_50);
         n++;
      end
      if (n < 20000) seen = 1'b1;
   endtask

   // Keyboard model: bits sampled while the device clock is high.
   // frame[0]=start, [8:1]=data, [9]=parity, [10]=stop.
   task automatic device_frame(input logic nack, input int abort_at,
                               output logic [10:0] frame);
      logic seen;
      frame = '1;
      wait_request(seen);
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("FAIL dev_request: no request-to-send seen, required one");
         return;
      end
      frame[0] = ps2_dat_in;
      repeat (20) @(negedge CLOCK_50);
      for (int i = 1; i <= 10; i++) begin
         dev_clk = 1'b0;
         if (i == abort_at) begin
            repeat (20) @(negedge CLOCK_50);
            resetn = 1'b0;
            @(negedge CLOCK_50);
            vectors++;
            if ({ps2_clk_pull, ps2_dat_pull, tx_busy, send_done, send_error} !== 5'b0) begin
               miscompares++;
               $display("FAIL reset_mid: pulls/busy/done/err=%b required 00000",
                        {ps2_clk_pull, ps2_dat_pull, tx_busy, send_done, send_error});
            end
            resetn  = 1'b1;
            dev_clk = 1'b1;
            dev_dat = 1'b1;
            return;
         end
         repeat (HALF) @(negedge CLOCK_50);
         dev_clk = 1'b1;
         repeat (10) @(negedge CLOCK_50);
         frame[i] = ps2_dat_in;
         repeat (HALF - 10) @(negedge CLOCK_50);
      end
      dev_dat = nack;
      repeat (HALF / 2) @(negedge CLOCK_50);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge CLOCK_50);
      dev_clk = 1'b1;
      repeat (HALF) @(negedge CLOCK_50);
      dev_dat = 1'b1;
   endtask

   task automatic wait_done(output logic got_done, output logic got_err);
      int n = 0;
      got_done = 1'b0;
      got_err  = 1'b0;
      while (n < 3000) begin
         @(negedge CLOCK_50);
         n++;
         if (send_done || send_error) begin
            got_done = send_done;
            got_err  = send_error;
            break;
         end
      end
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      vectors++;
      if ({tx_busy, send_done, send_error, ps2_clk_pull, ps2_dat_pull} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_state: got %b required 00000",
                  {tx_busy, send_done, send_error, ps2_clk_pull, ps2_dat_pull});
      end
      resetn = 1'b1;
      repeat (3) @(negedge CLOCK_50);
   endtask

   task automatic test_send_ed;
      logic [10:0] frame, exp;
      logic d, e;
      int errs0 = err_cnt;
      exp = {1'b1, 1'b1, 8'hED, 1'b0};
      start_send(8'hED);
      vectors++;
      if ({tx_busy, ps2_clk_pull} !== 2'b11) begin
         miscompares++;
         $display("FAIL ed_accept: busy/clk_pull=%b required 11", {tx_busy, ps2_clk_pull});
      end
      device_frame(1'b0, 0, frame);
      vectors++;
      if (frame !== exp) begin
         miscompares++;
         $display("FAIL ed_frame: line bits %b required %b", frame, exp);
      end
      vectors++;
      if (last_clk_run !== INH) begin
         miscompares++;
         $display("FAIL ed_inhibit: clk_pull high %0d cycles required %0d", last_clk_run, INH);
      end
      wait_done(d, e);
      vectors++;
      if ({d, e, tx_busy} !== 3'b101) begin
         miscompares++;
         $display("FAIL ed_done: done/err/busy=%b required 101", {d, e, tx_busy});
      end
      @(negedge CLOCK_50);
      vectors++;
      if ({send_done, tx_busy, ps2_clk_pull, ps2_dat_pull} !== 4'b0000) begin
         miscompares++;
         $display("FAIL ed_after: done/busy/pulls=%b required 0000",
                  {send_done, tx_busy, ps2_clk_pull, ps2_dat_pull});
      end
      vectors++;
      if (err_cnt !== errs0) begin
         miscompares++;
         $display("FAIL ed_no_err: error pulses %0d required 0", err_cnt - errs0);
      end
   endtask

   task automatic test_back_to_back;
      logic [10:0] frame, exp;
      logic d, e;
      exp = {1'b1, 1'b1, 8'h00, 1'b0};
      start_send(8'h00);
      device_frame(1'b0, 0, frame);
      vectors++;
      if (frame !== exp) begin
         miscompares++;
         $display("FAIL b2b_frame0: line bits %b required %b", frame, exp);
      end
      wait_done(d, e);
      vectors++;
      if ({d, e} !== 2'b10) begin
         miscompares++;
         $display("FAIL b2b_done0: done/err=%b required 10", {d, e});
      end
      send_data  = 8'h01;
      send_valid = 1'b1;
      @(negedge CLOCK_50);
      vectors++;
      if ({tx_busy, ps2_clk_pull} !== 2'b00) begin
         miscompares++;
         $display("FAIL b2b_pulse_ignore: busy/clk_pull=%b required 00", {tx_busy, ps2_clk_pull});
      end
      @(negedge CLOCK_50);
      send_valid = 1'b0;
      vectors++;
      if ({tx_busy, ps2_clk_pull} !== 2'b11) begin
         miscompares++;
         $display("FAIL b2b_accept: busy/clk_pull=%b required 11", {tx_busy, ps2_clk_pull});
      end
      exp = {1'b1, 1'b0, 8'h01, 1'b0};
      device_frame(1'b0, 0, frame);
      vectors++;
      if (frame !== exp) begin
         miscompares++;
         $display("FAIL b2b_frame1: line bits %b required %b", frame, exp);
      end
      wait_done(d, e);
      vectors++;
      if ({d, e} !== 2'b10) begin
         miscompares++;
         $display("FAIL b2b_done1: done/err=%b required 10", {d, e});
      end
      repeat (3) @(negedge CLOCK_50);
   endtask

   task automatic test_start_timeout;
      logic seen;
      int n = 0;
      int dones0 = done_cnt;
      start_send(8'hF4);
      wait_request(seen);
      while (!send_error && n < START + 100) begin
         @(negedge CLOCK_50);
         n++;
      end
      vectors++;
      if (n !== START + 2) begin
         miscompares++;
         $display("FAIL start_timeout: error after %0d cycles required %0d", n, START + 2);
      end
      vectors++;
      if ({send_error, ps2_clk_pull, ps2_dat_pull} !== 3'b100) begin
         miscompares++;
         $display("FAIL start_timeout_lines: err/pulls=%b required 100",
                  {send_error, ps2_clk_pull, ps2_dat_pull});
      end
      @(negedge CLOCK_50);
      vectors++;
      if ({tx_busy, done_cnt - dones0} !== {1'b0, 32'd0}) begin
         miscompares++;
         $display("FAIL start_timeout_after: busy=%b dones=%0d required 0 0",
                  tx_busy, done_cnt - dones0);
      end
      repeat (3) @(negedge CLOCK_50);
   endtask

   task automatic test_nack;
      logic [10:0] frame, exp;
      int dones0 = done_cnt;
      int errs0  = err_cnt;
      exp = {1'b1, 1'b1, 8'h55, 1'b0};
      start_send(8'h55);
      device_frame(1'b1, 0, frame);
      repeat (10) @(negedge CLOCK_50);
      vectors++;
      if (frame !== exp) begin
         miscompares++;
         $display("FAIL nack_frame: line bits %b required %b", frame, exp);
      end
      vectors++;
      if (err_cnt - errs0 !== 1 || done_cnt - dones0 !== 0) begin
         miscompares++;
         $display("FAIL nack_pulses: err=%0d done=%0d required 1 0",
                  err_cnt - errs0, done_cnt - dones0);
      end
      vectors++;
      if ({tx_busy, ps2_clk_pull, ps2_dat_pull} !== 3'b000) begin
         miscompares++;
         $display("FAIL nack_lines: busy/pulls=%b required 000",
                  {tx_busy, ps2_clk_pull, ps2_dat_pull});
      end
   endtask

   task automatic test_reset_mid;
      logic [10:0] frame, exp;
      logic d, e;
      int dones0 = done_cnt;
      int errs0  = err_cnt;
      start_send(8'hA5);
      device_frame(1'b0, 4, frame);
      repeat (20) @(negedge CLOCK_50);
      vectors++;
      if (err_cnt - errs0 !== 0 || done_cnt - dones0 !== 0) begin
         miscompares++;
         $display("FAIL reset_mid_pulses: err=%0d done=%0d required 0 0",
                  err_cnt - errs0, done_cnt - dones0);
      end
      exp = {1'b1, 1'b1, 8'hFF, 1'b0};
      start_send(8'hFF);
      device_frame(1'b0, 0, frame);
      vectors++;
      if (frame !== exp) begin
         miscompares++;
         $display("FAIL reset_mid_resend: line bits %b required %b", frame, exp);
      end
      wait_done(d, e);
      vectors++;
      if ({d, e} !== 2'b10) begin
         miscompares++;
         $display("FAIL reset_mid_done: done/err=%b required 10", {d, e});
      end
      repeat (3) @(negedge CLOCK_50);
   endtask

   task automatic test_hold_valid;
      logic [10:0] frame, exp;
      logic d, e;
      exp = {1'b1, 1'b0, 8'hF4, 1'b0};
      send_data  = 8'hF4;
      send_valid = 1'b1;
      @(negedge CLOCK_50);
      send_data = 8'h12;
      device_frame(1'b0, 0, frame);
      wait_done(d, e);
      send_valid = 1'b0;
      vectors++;
      if (frame !== exp) begin
         miscompares++;
         $display("FAIL hold_frame: line bits %b required %b", frame, exp);
      end
      vectors++;
      if ({d, e} !== 2'b10) begin
         miscompares++;
         $display("FAIL hold_done: done/err=%b required 10", {d, e});
      end
      repeat (5) @(negedge CLOCK_50);
      vectors++;
      if ({tx_busy, ps2_clk_pull, ps2_dat_pull} !== 3'b000) begin
         miscompares++;
         $display("FAIL hold_idle: busy/pulls=%b required 000",
                  {tx_busy, ps2_clk_pull, ps2_dat_pull});
      end
   endtask

   initial begin
      test_reset();
      test_send_ed();
      test_back_to_back();
      test_start_timeout();
      test_nack();
      test_reset_mid();
      test_hold_valid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
